// File: rtl/multi_port_fifo_if.sv
// Multi-lane valid/ready handshake bundle.
// The master drives valid/data, the slave drives ready.
interface multi_port_fifo_if #(
    parameter int N = 2,
    parameter int W = 32
);
    logic [N-1:0]        valid;
    logic [N-1:0]        ready;
    logic [N-1:0][W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/multi_port_fifo.sv
// Multi-lane circular FIFO with prefix enqueue/dequeue,
// single-cycle flush and exact occupancy count.
module multi_port_fifo #(
    parameter int N_ENTRIES   = 8,
    parameter int ENTRY_WIDTH = 32,
    parameter int N_ENQ       = 2,
    parameter int N_DEQ       = 2,
    localparam int CTR_WIDTH  = $clog2(N_ENTRIES) + 1
) (
    input  logic                 clk,
    input  logic                 rst_aL,
    input  logic                 flush,
    multi_port_fifo_if.slave     enq,
    multi_port_fifo_if.master    deq,
    output logic [CTR_WIDTH-1:0] count
);
    localparam int PTR_W = CTR_WIDTH - 1;

    typedef logic [ENTRY_WIDTH-1:0] entry_t;

    logic [CTR_WIDTH-1:0] enq_ctr_q, enq_ctr_d;
    logic [CTR_WIDTH-1:0] deq_ctr_q, deq_ctr_d;
    logic [CTR_WIDTH-1:0] free;
    logic [CTR_WIDTH-1:0] n_enq, n_deq;
    logic [PTR_W-1:0]     enq_ptr, deq_ptr;
    logic [N_ENQ-1:0]     enq_acc;
    logic [N_DEQ-1:0]     deq_acc;
    logic                 enq_go, deq_go;
    entry_t               mem_q [N_ENTRIES];
    entry_t               mem_d [N_ENTRIES];

    // Counters carry one extra bit so full and empty differ.
    assign count   = enq_ctr_q - deq_ctr_q;
    assign free    = CTR_WIDTH'(N_ENTRIES) - count;
    assign enq_ptr = enq_ctr_q[PTR_W-1:0];
    assign deq_ptr = deq_ctr_q[PTR_W-1:0];

    always_comb begin
        enq.ready = '0;
        for (int i = 0; i < N_ENQ; i++) begin
            enq.ready[i] = !flush && (free > CTR_WIDTH'(i));
        end
    end

    always_comb begin
        deq.valid = '0;
        deq.data  = '0;
        for (int i = 0; i < N_DEQ; i++) begin
            deq.valid[i] = !flush && (count > CTR_WIDTH'(i));
            deq.data[i]  = mem_q[deq_ptr + PTR_W'(i)];
        end
    end

    // Readiness is monotone in lane index, so a running AND
    // gives the accepted prefix.
    always_comb begin
        enq_acc = '0;
        n_enq   = '0;
        enq_go  = 1'b1;
        for (int i = 0; i < N_ENQ; i++) begin
            enq_go     = enq_go && enq.valid[i] && enq.ready[i];
            enq_acc[i] = enq_go;
            n_enq      = n_enq + CTR_WIDTH'(enq_go);
        end
    end

    always_comb begin
        deq_acc = '0;
        n_deq   = '0;
        deq_go  = 1'b1;
        for (int i = 0; i < N_DEQ; i++) begin
            deq_go     = deq_go && deq.ready[i] && deq.valid[i];
            deq_acc[i] = deq_go;
            n_deq      = n_deq + CTR_WIDTH'(deq_go);
        end
    end

    always_comb begin
        mem_d     = mem_q;
        enq_ctr_d = enq_ctr_q + n_enq;
        deq_ctr_d = deq_ctr_q + n_deq;
        for (int i = 0; i < N_ENQ; i++) begin
            if (enq_acc[i]) begin
                mem_d[enq_ptr + PTR_W'(i)] = enq.data[i];
            end
        end
        if (flush) begin
            enq_ctr_d = '0;
            deq_ctr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            enq_ctr_q <= '0;
            deq_ctr_q <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            enq_ctr_q <= enq_ctr_d;
            deq_ctr_q <= deq_ctr_d;
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
endmodule

// File: tb/tb_multi_port_fifo.sv
// Directed scoreboard bench for multi_port_fifo
// with default parameters (8 entries, 2+2 lanes).
module tb_multi_port_fifo;
    logic       clk = 1'b0;
    logic       rst_aL;
    logic       flush;
    logic [3:0] cnt;
    int         ntests = 0;
    int         nfail  = 0;
    int         seq    = 32'h100;
    logic [31:0] q[$];

    multi_port_fifo_if #(.N(2), .W(32)) enq_if ();
    multi_port_fifo_if #(.N(2), .W(32)) deq_if ();

    multi_port_fifo #(
        .N_ENTRIES  (8),
        .ENTRY_WIDTH(32),
        .N_ENQ      (2),
        .N_DEQ      (2)
    ) dut (
        .clk   (clk),
        .rst_aL(rst_aL),
        .flush (flush),
        .enq   (enq_if.slave),
        .deq   (deq_if.master),
        .count (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs at the falling edge,
    // then advance the scoreboard by the expected handshakes.
    task automatic step(input logic [1:0] ev, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [1:0] dr,
                        input logic fl);
        logic [1:0]  er, dv;
        logic [31:0] d [2];
        int          fr, ne, nd;
        logic        go;
        d[0] = d0;
        d[1] = d1;
        enq_if.valid   = ev;
        enq_if.data[0] = d0;
        enq_if.data[1] = d1;
        deq_if.ready   = dr;
        flush          = fl;
        @(negedge clk);
        fr = 8 - q.size();
        for (int i = 0; i < 2; i++) begin
            er[i] = !fl && (fr > i);
            dv[i] = !fl && (q.size() > i);
        end
        chk("count", 32'(cnt), 32'(q.size()));
        chk("enq_ready", 32'(enq_if.ready), 32'(er));
        chk("deq_valid", 32'(deq_if.valid), 32'(dv));
        for (int i = 0; i < 2; i++) begin
            if (dv[i]) chk($sformatf("deq_data%0d", i), deq_if.data[i], q[i]);
        end
        ne = 0;
        go = 1'b1;
        for (int i = 0; i < 2; i++) begin
            go = go && ev[i] && er[i];
            if (go) ne++;
        end
        nd = 0;
        go = 1'b1;
        for (int i = 0; i < 2; i++) begin
            go = go && dr[i] && dv[i];
            if (go) nd++;
        end
        repeat (nd) void'(q.pop_front());
        for (int i = 0; i < ne; i++) q.push_back(d[i]);
        if (fl) q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_aL        = 1'b0;
        flush         = 1'b0;
        enq_if.valid  = '0;
        enq_if.data   = '0;
        deq_if.ready  = '0;
        #1;
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_enq_ready", 32'(enq_if.ready), 32'h3);
        chk("rst_deq_valid", 32'(deq_if.valid), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_aL = 1'b1;

        // Dual enqueue, then ordered dequeue.
        step(2'b11, 32'hA, 32'hB, 2'b00, 1'b0);
        step(2'b11, 32'hC, 32'hD, 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);

        // Fill to full with partial readiness at 7.
        step(2'b01, 32'h100, 32'hDEAD, 2'b00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(2'b11, 32'h101 + 2 * k, 32'h102 + 2 * k, 2'b00, 1'b0);
        end
        step(2'b11, 32'h107, 32'h108, 2'b00, 1'b0);
        step(2'b11, 32'h1F0, 32'h1F1, 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);

        // Non-prefix handshakes move nothing.
        step(2'b10, 32'h2F0, 32'h2F1, 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b10, 1'b0);

        // Steady state across slot and counter wrap.
        step(2'b01, 32'h300, 32'h0, 2'b00, 1'b0);
        seq = 32'h400;
        for (int k = 0; k < 10; k++) begin
            step(2'b11, seq, seq + 1, 2'b11, 1'b0);
            seq += 2;
        end

        // Flush at count 5 with traffic offered.
        step(2'b01, 32'h500, 32'h0, 2'b00, 1'b0);
        step(2'b11, 32'h5F0, 32'h5F1, 2'b11, 1'b1);
        step(2'b01, 32'hE, 32'h0, 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);

        // Asynchronous reset mid-traffic at count 5.
        step(2'b11, 32'h600, 32'h601, 2'b00, 1'b0);
        step(2'b11, 32'h602, 32'h603, 2'b00, 1'b0);
        step(2'b01, 32'h604, 32'h0, 2'b00, 1'b0);
        enq_if.valid = 2'b11;
        deq_if.ready = 2'b01;
        #2;
        chk("pre_rst_count", 32'(cnt), 32'd5);
        rst_aL = 1'b0;
        #1;
        chk("mid_rst_count", 32'(cnt), 32'd0);
        chk("mid_rst_enq_ready", 32'(enq_if.ready), 32'h3);
        chk("mid_rst_deq_valid", 32'(deq_if.valid), 32'h0);
        q.delete();
        @(posedge clk);
        #1;
        chk("held_rst_count", 32'(cnt), 32'd0);
        rst_aL = 1'b1;
        step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        step(2'b11, 32'h700, 32'h701, 2'b00, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
